m_hzd_scoreboard: RTL and testbench
===================================

// Module: m_hzd_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding unit for the pipelined MIPS-subset cores; it replaces ad-hoc per-core forwarding muxes.
//  Sits at the ID stage and holds a shadow pipeline of destination tags for NSTG post-ID stages.
//  Supplies forwarded source operands, and stalls issue on load-use hazards, which the current cores do not detect.
//  Also supports flush, and keeps issue/stall performance counters.
// PARAMETERS
//  DW     32  datapath width
//  NREG   32  architectural registers; register 0 is hard-wired zero and never matches
//  AW     5   register index width; must equal $clog2(NREG)
//  NSTG   3   tracked stages after ID: 0=EX, 1=MEM, 2=WB; legal range 2..8
//  LDRDY  2   first stage index at which a load result is valid on w_stg_data; legal range 1..NSTG-1
// PORTS
//  w_clk       in   1        clock; all state updates on posedge
//  w_rst       in   1        asynchronous reset, active-high
//  w_iss_vld   in   1        ID holds a valid instruction requesting issue
//  w_rs        in   AW       source A register index
//  w_rt        in   AW       source B register index
//  w_rd        in   AW       destination register index
//  w_we        in   1        instruction writes w_rd
//  w_ld        in   1        instruction is a load
//  w_rrs       in   DW       register file read data for w_rs
//  w_rrt       in   DW       register file read data for w_rt
//  w_flush     in   1        kill the instruction in stage 0 and block this cycle's issue
//  w_stg_data  in   NSTG*DW  result of stage k, on bits [k*DW +: DW]
//  w_opa       out  DW       forwarded operand A
//  w_opb       out  DW       forwarded operand B
//  w_stall     out  1        ID must hold; a bubble enters stage 0
//  w_iss       out  1        issue accepted: w_iss_vld & ~w_stall & ~w_flush
//  w_busy      out  1        any stage entry valid
//  r_iss_cnt   out  32       accepted issues, saturating counter
//  r_stall_cnt out  32       cycles with w_iss_vld & w_stall, saturating counter
// BEHAVIOUR
//  - State: NSTG entries {v, rd, ld}. All outputs except the counters are combinational from the entries and inputs.
//  - Reset (async): all entry v=0; r_iss_cnt=0; r_stall_cnt=0. So w_stall=0, w_busy=0, w_opa=w_rrs, w_opb=w_rrt.
//  - Match for source s at stage k: v[k] & rd[k]==s & s!=0.
//  - Forward priority: youngest wins (lowest k); no match -> register file data.
//  - WB-stage forwarding covers the same-cycle register file write-then-read case.
//  - Hazard: the youngest match has ld=1 & k<LDRDY -> w_stall=1, asserted only when w_iss_vld=1.
//  - An older ready match behind an unready younger load still stalls, because the youngest match governs.
//  - Each posedge, entries shift: entry[k+1] <= entry[k]; the entry at NSTG-1 retires.
//  - Entry[0] loads {1, w_rd, w_ld} if w_iss & w_we; otherwise entry[0].v <= 0.
//  - Non-writing instructions (stores, branches, halt) enter as bubbles.
//  - Flush: w_flush=1 -> entry[0] is not shifted into entry[1] (the killed instruction's tag is dropped).
//  - Under flush, the new entry[0] is a bubble and w_iss=0. Flush beats issue when both occur.
//  - Flush during stall: flush wins; no stall count that cycle.
//  - Latency: a consumer issued 1 cycle after an ALU producer gets the stage-0 value, with no bubble.
//  - Default parameters, load followed by a dependent instruction: 2 stall cycles, then forwarding from WB.
//  - Counters: +1 per qualifying cycle, held at 32'hFFFF_FFFF (no wrap).
//  - rs==rt with a match: both operands get the same forwarded value.
//  - Reset asserted mid-operation clears all entries immediately; no pending hazard survives.
// TESTING
//  1. addi $1,$0,0x20 then add $2,$1,$1 back-to-back -> no stall; w_opa=w_opb=stage-0 data 0x20.
//  2. lw $12,0($0) then add $13,$12,$1 -> w_stall=1 for exactly 2 cycles.
//     Then w_opa=stage-2 data; r_stall_cnt=2.
//  3. Writes to $5 at stages 0,1,2 with different data -> operand equals the stage-0 value.
//     Same test with rs=$0 -> operand 0 and no stall.
//  4. lw $3 in stage 0, w_flush=1 with w_iss_vld=1 -> w_iss=0, stall counter unchanged.
//     Next cycle a consumer of $3 does not stall.
//  5. Assert w_rst mid-load-stall -> entries clear asynchronously, w_stall=0, counters 0 before the next edge.
//  6. Preload r_iss_cnt near 32'hFFFF_FFFF, then 3 issues -> counter saturates at 32'hFFFF_FFFF.
//     Also rerun test 2 with NSTG=5, LDRDY=3 -> 3 stall cycles.

Source files
------------

// File: rtl/m_hzd_scoreboard.sv
// Hazard/forwarding scoreboard for the ID stage: tracks destination tags of the
// NSTG post-ID stages, forwards the youngest matching result and stalls on load-use.
module m_hzd_scoreboard #(
  parameter int          DW       = 32,
  parameter int          NREG     = 32,
  parameter int          AW       = 5,
  parameter int          NSTG     = 3,
  parameter int          LDRDY    = 2,
  parameter logic [31:0] CNT_INIT = 32'h0000_0000
) (
  input  logic               w_clk,
  input  logic               w_rst,
  input  logic               w_iss_vld,
  input  logic [AW-1:0]      w_rs,
  input  logic [AW-1:0]      w_rt,
  input  logic [AW-1:0]      w_rd,
  input  logic               w_we,
  input  logic               w_ld,
  input  logic [DW-1:0]      w_rrs,
  input  logic [DW-1:0]      w_rrt,
  input  logic               w_flush,
  input  logic [NSTG*DW-1:0] w_stg_data,
  output logic [DW-1:0]      w_opa,
  output logic [DW-1:0]      w_opb,
  output logic               w_stall,
  output logic               w_iss,
  output logic               w_busy,
  output logic [31:0]        r_iss_cnt,
  output logic [31:0]        r_stall_cnt
);

  // Shadow pipeline entry k describes the instruction currently in stage k.
  logic [NSTG-1:0] r_v;
  logic [NSTG-1:0] r_ld;
  logic [AW-1:0]   r_rd [NSTG];

  logic a_hz;
  logic b_hz;

  // Register 0 never matches; indices beyond NREG are treated the same way.
  function automatic logic f_src_ok(input logic [AW-1:0] s);
    return (s != '0) && (int'(s) < NREG);
  endfunction

  // Scan oldest to youngest so the youngest match overwrites and governs both
  // the forwarded value and the hazard decision.
  always_comb begin
    w_opa = w_rrs;
    w_opb = w_rrt;
    a_hz  = 1'b0;
    b_hz  = 1'b0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (r_v[k] && (r_rd[k] == w_rs) && f_src_ok(w_rs)) begin
        w_opa = w_stg_data[k*DW +: DW];
        a_hz  = r_ld[k] && (k < LDRDY);
      end
      if (r_v[k] && (r_rd[k] == w_rt) && f_src_ok(w_rt)) begin
        w_opb = w_stg_data[k*DW +: DW];
        b_hz  = r_ld[k] && (k < LDRDY);
      end
    end
  end

  // Issue handshake: w_iss_vld is the request and ~w_stall the ready; an
  // instruction transfers into stage 0 only when w_iss = vld & ~stall & ~flush,
  // and ID must hold the same instruction while it is not accepted.
  assign w_stall = w_iss_vld & (a_hz | b_hz);
  assign w_iss   = w_iss_vld & ~w_stall & ~w_flush;
  assign w_busy  = |r_v;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_v  <= '0;
      r_ld <= '0;
      for (int k = 0; k < NSTG; k++) begin
        r_rd[k] <= '0;
      end
    end else begin
      r_v[0]  <= w_iss & w_we;
      r_rd[0] <= w_rd;
      r_ld[0] <= w_ld;
      // A flush drops the stage-0 instruction instead of advancing it.
      r_v[1]  <= r_v[0] & ~w_flush;
      r_rd[1] <= r_rd[0];
      r_ld[1] <= r_ld[0];
      for (int k = 2; k < NSTG; k++) begin
        r_v[k]  <= r_v[k-1];
        r_rd[k] <= r_rd[k-1];
        r_ld[k] <= r_ld[k-1];
      end
    end
  end

  // Saturating performance counters; a flushed cycle never counts as a stall.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_iss_cnt   <= CNT_INIT;
      r_stall_cnt <= CNT_INIT;
    end else begin
      if (w_iss && (r_iss_cnt != 32'hFFFF_FFFF)) begin
        r_iss_cnt <= r_iss_cnt + 32'd1;
      end
      if (w_iss_vld && w_stall && !w_flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_m_hzd_scoreboard.sv
// Directed bench for m_hzd_scoreboard: default instance plus an NSTG=5/LDRDY=3
// instance whose counters start near saturation.
module tb_m_hzd_scoreboard;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iss_vld, we, ld, flush;
  logic [4:0] rs, rt, rd;
  logic [31:0] rrs, rrt;
  logic [3*DW-1:0] stg;
  logic [5*DW-1:0] stg5;

  logic [31:0] opa, opb, iss_cnt, stall_cnt;
  logic        stall, iss, busy;
  logic [31:0] b_opa, b_opb, b_iss_cnt, b_stall_cnt;
  logic        b_stall, b_iss, b_busy;

  int n_run  = 0;
  int n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  m_hzd_scoreboard dut (
    .w_clk(clk), .w_rst(rst), .w_iss_vld(iss_vld), .w_rs(rs), .w_rt(rt),
    .w_rd(rd), .w_we(we), .w_ld(ld), .w_rrs(rrs), .w_rrt(rrt),
    .w_flush(flush), .w_stg_data(stg), .w_opa(opa), .w_opb(opb),
    .w_stall(stall), .w_iss(iss), .w_busy(busy), .r_iss_cnt(iss_cnt),
    .r_stall_cnt(stall_cnt)
  );

  m_hzd_scoreboard #(.NSTG(5), .LDRDY(3), .CNT_INIT(32'hFFFF_FFFD)) dut5 (
    .w_clk(clk), .w_rst(rst), .w_iss_vld(iss_vld), .w_rs(rs), .w_rt(rt),
    .w_rd(rd), .w_we(we), .w_ld(ld), .w_rrs(rrs), .w_rrt(rrt),
    .w_flush(flush), .w_stg_data(stg5), .w_opa(b_opa), .w_opb(b_opb),
    .w_stall(b_stall), .w_iss(b_iss), .w_busy(b_busy), .r_iss_cnt(b_iss_cnt),
    .r_stall_cnt(b_stall_cnt)
  );

  // driver tasks
  task automatic drive(input logic v, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic w, input logic l);
    iss_vld = v; rs = s; rt = t; rd = d; we = w; ld = l;
    rrs = (s == 5'd0) ? 32'h0 : 32'hA000_0000 + {27'b0, s};
    rrt = (t == 5'd0) ? 32'h0 : 32'hA000_0000 + {27'b0, t};
  endtask

  task automatic set_stg(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    stg = {d2, d1, d0};
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // checkers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    flush = 1'b0;
    drive(1'b0, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    set_stg(32'h1000_0000, 32'h1000_0001, 32'h1000_0002);
    for (int k = 0; k < 5; k++) stg5[k*DW +: DW] = 32'h5500_0000 + 32'(k);

    // reset state
    #2;
    chkb("rst_stall", stall, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chk("rst_opa", opa, 32'hA000_0003);
    chk("rst_opb", opb, 32'hA000_0004);
    chk("rst_iss_cnt", iss_cnt, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // 1: ALU producer followed by a back-to-back consumer
    drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    at_neg();
    chkb("t1_addi_iss", iss, 1'b1);
    cyc();
    drive(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0);
    set_stg(32'h20, 32'h77, 32'h88);
    at_neg();
    chk("t1_opa", opa, 32'h20);
    chk("t1_opb", opb, 32'h20);
    chkb("t1_stall", stall, 1'b0);
    cyc();

    // 2: load-use stalls two cycles then forwards from WB
    drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
    at_neg();
    chkb("t2_lw_iss", iss, 1'b1);
    cyc();
    drive(1'b1, 5'd12, 5'd1, 5'd13, 1'b1, 1'b0);
    set_stg(32'h100, 32'h111, 32'h222);
    at_neg();
    chkb("t2_stall_c1", stall, 1'b1);
    chkb("t2_iss_c1", iss, 1'b0);
    chk("t2_opb_wb", opb, 32'h222);
    cyc();
    at_neg();
    chkb("t2_stall_c2", stall, 1'b1);
    chk("t2_opb_rf", opb, 32'hA000_0001);
    cyc();
    at_neg();
    chkb("t2_stall_c3", stall, 1'b0);
    chkb("t2_iss_c3", iss, 1'b1);
    chk("t2_opa_wb", opa, 32'h222);
    chk("t2_stall_cnt", stall_cnt, 32'd2);
    chk("t2_iss_cnt", iss_cnt, 32'd3);
    cyc();

    // 3: $5 written in every stage, youngest wins; $0 never forwards
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    cyc(); cyc(); cyc();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    set_stg(32'h0A, 32'h0B, 32'h0C);
    at_neg();
    chk("t3_opa_young", opa, 32'h0A);
    chk("t3_opb_same", opb, 32'h0A);
    chk("t3_iss_cnt", iss_cnt, 32'd7);
    drive(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
    #1;
    chk("t3_opa_zero", opa, 32'h0);
    chk("t3_opb_young", opb, 32'h0A);
    chkb("t3_stall_zero", stall, 1'b0);
    cyc();

    // unready younger load governs over an older ready match; flush it
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    set_stg(32'h50, 32'h51, 32'h52);
    at_neg();
    chkb("t3_young_ld_stall", stall, 1'b1);
    flush = 1'b1;
    #1;
    chkb("t3_flush_iss", iss, 1'b0);
    chk("t3_flush_iss_cnt", iss_cnt, 32'd9);
    cyc();
    flush = 1'b0;
    at_neg();
    chkb("t3_post_flush_busy", busy, 1'b0);
    chkb("t3_post_flush_stall", stall, 1'b0);
    chk("t3_post_flush_opa", opa, 32'hA000_0005);
    chk("t3_post_flush_stall_cnt", stall_cnt, 32'd2);
    cyc();

    // 4: flush a load in stage 0, consumer afterwards does not stall
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'd3, 5'd0, 5'd7, 1'b1, 1'b0);
    flush = 1'b1;
    at_neg();
    chkb("t4_flush_iss", iss, 1'b0);
    cyc();
    flush = 1'b0;
    at_neg();
    chkb("t4_stall", stall, 1'b0);
    chkb("t4_iss", iss, 1'b1);
    chk("t4_stall_cnt", stall_cnt, 32'd2);
    chk("t4_iss_cnt", iss_cnt, 32'd11);
    cyc();

    // 5: reset asserted during a load stall
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0);
    at_neg();
    chkb("t5_stall_pre", stall, 1'b1);
    chkb("t5_busy_pre", busy, 1'b1);
    rst = 1'b1;
    #1;
    chkb("t5_stall_rst", stall, 1'b0);
    chkb("t5_busy_rst", busy, 1'b0);
    chk("t5_opa_rst", opa, 32'hA000_0009);
    chk("t5_iss_cnt_rst", iss_cnt, 32'h0);
    chk("t5_stall_cnt_rst", stall_cnt, 32'h0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // 6: counter saturation and NSTG=5/LDRDY=3 load-use latency
    drive(1'b1, 5'd0, 5'd0, 5'd20, 1'b1, 1'b0);
    at_neg();
    chk("t6_cnt_init", b_iss_cnt, 32'hFFFF_FFFD);
    cyc();
    drive(1'b1, 5'd0, 5'd0, 5'd21, 1'b1, 1'b0);
    at_neg();
    chk("t6_cnt_1", b_iss_cnt, 32'hFFFF_FFFE);
    cyc();
    drive(1'b1, 5'd0, 5'd0, 5'd22, 1'b1, 1'b0);
    at_neg();
    chk("t6_cnt_2", b_iss_cnt, 32'hFFFF_FFFF);
    cyc();
    drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
    at_neg();
    chk("t6_cnt_sat", b_iss_cnt, 32'hFFFF_FFFF);
    chkb("t6_lw_iss", b_iss, 1'b1);
    cyc();
    drive(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0);
    set_stg(32'h301, 32'h302, 32'h333);
    at_neg();
    chkb("t6_def_stall_c1", stall, 1'b1);
    chkb("t6_n5_stall_c1", b_stall, 1'b1);
    chk("t6_n5_stall_cnt_c1", b_stall_cnt, 32'hFFFF_FFFD);
    cyc();
    at_neg();
    chkb("t6_def_stall_c2", stall, 1'b1);
    chkb("t6_n5_stall_c2", b_stall, 1'b1);
    chk("t6_n5_stall_cnt_c2", b_stall_cnt, 32'hFFFF_FFFE);
    cyc();
    at_neg();
    chkb("t6_def_stall_c3", stall, 1'b0);
    chk("t6_def_opa_wb", opa, 32'h333);
    chkb("t6_n5_stall_c3", b_stall, 1'b1);
    chk("t6_n5_stall_cnt_c3", b_stall_cnt, 32'hFFFF_FFFF);
    cyc();
    at_neg();
    chkb("t6_n5_stall_c4", b_stall, 1'b0);
    chkb("t6_n5_iss_c4", b_iss, 1'b1);
    chk("t6_n5_opa", b_opa, 32'h5500_0003);
    chk("t6_n5_opb", b_opb, 32'h0);
    chk("t6_n5_stall_cnt_sat", b_stall_cnt, 32'hFFFF_FFFF);
    chk("t6_def_stall_cnt", stall_cnt, 32'd2);
    cyc();

    // final report
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
